// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serialises valid/ready words MSB-first onto an external 1-bit detector and counts its hits.
// Build option SEQ_DET_CTRL_WORD_CLR_EN adds a LOAD cycle that clears the detector before every word.
//
// state | meaning
// IDLE  | waiting for a word, s_ready high
// LOAD  | det_clr pulse, no bit sent (SEQ_DET_CTRL_WORD_CLR_EN only)
// SHIFT | one word bit per cycle on det_bit
// DRAIN | count the hit for the final bit, may accept the next word
module seq_det_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              det_bit,
    output logic              det_clr,
    input  logic              det_match,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              word_done,
    output logic              word_match
);
    localparam int BIT_CW = $clog2(DATA_W);
    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
`ifdef SEQ_DET_CTRL_WORD_CLR_EN
        , LOAD = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BIT_CW-1:0] bit_cnt;
    logic              bit_vld_q;
    logic              hit_acc;
    logic              hit;
    logic              accept;

    assign s_ready = (state == IDLE) || (state == DRAIN);
    assign accept  = s_valid && s_ready;
    // A hit in the same cycle as cnt_clr is dropped from both the count and word_match.
    assign hit     = bit_vld_q && det_match && !cnt_clr;

`ifndef SEQ_DET_CTRL_WORD_CLR_EN
    assign det_clr = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            det_bit    <= 1'b0;
            bit_vld_q  <= 1'b0;
            hit_acc    <= 1'b0;
            match_cnt  <= '0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
            word_match <= 1'b0;
`ifdef SEQ_DET_CTRL_WORD_CLR_EN
            det_clr    <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            bit_vld_q <= (state == SHIFT);

            if (cnt_clr)
                match_cnt <= '0;
            else if (hit && (match_cnt != CNT_MAX))
                match_cnt <= match_cnt + 1'b1;

            if (hit)
                hit_acc <= 1'b1;

            case (state)
`ifdef SEQ_DET_CTRL_WORD_CLR_EN
                LOAD: begin
                    det_clr <= 1'b0;
                    det_bit <= shreg[DATA_W-1];
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    state   <= SHIFT;
                end
`endif
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        state <= DRAIN;
                    end else begin
                        det_bit <= shreg[DATA_W-1];
                        shreg   <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    // det_bit keeps its last value so a continuously running detector sees a steady input
                    word_done  <= 1'b1;
                    word_match <= hit_acc || hit;
                    hit_acc    <= 1'b0;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: ;
            endcase

            if (accept) begin
                // In DRAIN word_match is still reporting the finishing word, so only clear it from IDLE
                if (state == IDLE)
                    word_match <= 1'b0;
                hit_acc <= 1'b0;
                busy    <= 1'b1;
                bit_cnt <= LAST_BIT;
`ifdef SEQ_DET_CTRL_WORD_CLR_EN
                state   <= LOAD;
                det_clr <= 1'b1;
                det_bit <= 1'b0;
                shreg   <= s_data;
`else
                state   <= SHIFT;
                det_bit <= s_data[DATA_W-1];
                shreg   <= {s_data[DATA_W-2:0], 1'b0};
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: vector table plus scoreboard bench for seq_det_ctrl, driving two instances
// (CNT_W=8 and CNT_W=2) each feeding a behavioural overlapping 11011 Moore detector.
module tb_seq_det_ctrl;
`ifdef SEQ_DET_CTRL_WORD_CLR_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif
    localparam int DW  = 8;
    localparam int LAT = DW + 2 + M;

    typedef struct {
        logic [7:0] data;
        bit         chain;
        int         hits_nm;
        int         hits_m;
    } vec_t;

    typedef struct {
        int   cnt;
        logic wm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0, s_valid2 = 1'b0;
    logic [7:0] s_data = '0, s_data2 = '0;
    logic       cnt_clr = 1'b0, cnt_clr2 = 1'b0;
    logic       s_ready, det_bit, det_clr, det_match, busy, word_done, word_match;
    logic       s_ready2, det_bit2, det_clr2, det_match2, busy2, word_done2, word_match2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [4:0] hist, hist2;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   clr_cnt = 0;
    int   exp_cnt = 0;
    int   exp_cnt2 = 0;
    exp_t sb[$];
    exp_t sb2[$];
    vec_t tbl[7];

    always #5 clk = ~clk;

    seq_det_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .det_bit(det_bit), .det_clr(det_clr), .det_match(det_match), .cnt_clr(cnt_clr),
        .match_cnt(match_cnt), .busy(busy), .word_done(word_done), .word_match(word_match)
    );

    seq_det_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
        .det_bit(det_bit2), .det_clr(det_clr2), .det_match(det_match2), .cnt_clr(cnt_clr2),
        .match_cnt(match_cnt2), .busy(busy2), .word_done(word_done2), .word_match(word_match2)
    );

    // External 11011 detector: out is high when the last five clocked bits are 11011.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        hist <= '0;
        else if (det_clr) hist <= '0;
        else              hist <= {hist[3:0], det_bit};
    end
    assign det_match = (hist == 5'b11011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         hist2 <= '0;
        else if (det_clr2) hist2 <= '0;
        else               hist2 <= {hist2[3:0], det_bit2};
    end
    assign det_match2 = (hist2 == 5'b11011);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Every bench wait goes through here so word_done is scored on each falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (det_clr) clr_cnt++;
            if (word_done) begin
                done_cnt++;
                if (sb.size() == 0) fail_now("spurious_word_done");
                else begin
                    e = sb.pop_front();
                    check("word_cnt", match_cnt, e.cnt);
                    check("word_match", word_match, e.wm);
                end
            end
            if (word_done2) begin
                if (sb2.size() == 0) fail_now("spurious_word_done2");
                else begin
                    e = sb2.pop_front();
                    check("word_cnt2", match_cnt2, e.cnt);
                    check("word_match2", word_match2, e.wm);
                end
            end
        end
    endtask

    task automatic push_exp(input int which, input int hits);
        exp_t e;
        if (which == 0) begin
            exp_cnt = (exp_cnt + hits > 255) ? 255 : exp_cnt + hits;
            e.cnt = exp_cnt;
            e.wm  = (hits > 0);
            sb.push_back(e);
        end else begin
            exp_cnt2 = (exp_cnt2 + hits > 3) ? 3 : exp_cnt2 + hits;
            e.cnt = exp_cnt2;
            e.wm  = (hits > 0);
            sb2.push_back(e);
        end
    endtask

    task automatic wait_idle(input int which);
        int n;
        n = 0;
        while (((which == 0) ? busy : busy2) !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) fail_now("idle_timeout");
        repeat (2) tick();
    endtask

    task automatic send(input int which, input logic [7:0] d, input int hits, input bit chain);
        int n;
        n = 0;
        if (which == 0) begin s_valid = 1'b1; s_data = d; end
        else begin s_valid2 = 1'b1; s_data2 = d; end
        while (((which == 0) ? s_ready : s_ready2) !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            fail_now("accept_timeout");
            s_valid  = 1'b0;
            s_valid2 = 1'b0;
        end else begin
            push_exp(which, hits);
            tick();
            if (which == 0) s_valid = 1'b0;
            else s_valid2 = 1'b0;
            if (!chain) wait_idle(which);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_det_bit"}, det_bit, 0);
        check({tag, "_det_clr"}, det_clr, 0);
        check({tag, "_match_cnt"}, match_cnt, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_word_done"}, word_done, 0);
        check({tag, "_word_match"}, word_match, 0);
        check({tag, "_s_ready"}, s_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        logic [7:0] a;
        int         snap;
        int         clr_base;

        // word, chain next word back-to-back, hits without / with per-word detector clear
        tbl[0] = '{8'b11011011, 1'b0, 2, 2};
        tbl[1] = '{8'b00000011, 1'b1, 0, 0};
        tbl[2] = '{8'b01100000, 1'b0, 1, 0};
        tbl[3] = '{8'b10110110, 1'b0, 1, 1};
        tbl[4] = '{8'b11111111, 1'b1, 0, 0};
        tbl[5] = '{8'b01111011, 1'b0, 2, 1};
        tbl[6] = '{8'b00000000, 1'b0, 0, 0};

        repeat (2) tick();
        check_reset("rst");
        reset = 1'b0;
        tick();

        // Single word with exact bit and completion timing.
        w = 8'b11011000;
        s_valid = 1'b1;
        s_data  = w;
        check("t1_ready", s_ready, 1);
        push_exp(0, 1);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) begin
                s_valid = 1'b0;
                check("t1_busy", busy, 1);
                check("t1_det_clr", det_clr, M);
            end
            if (k > M && k <= DW + M) check($sformatf("t1_bit%0d", k - M), det_bit, w[DW - (k - M)]);
            if (k == LAT - 1) check("t1_done_early", word_done, 0);
            if (k == LAT) begin
                check("t1_done", word_done, 1);
                check("t1_cnt", match_cnt, 1);
            end
        end
        wait_idle(0);

        // s_valid held through SHIFT with changing data: only the DRAIN-cycle word is taken next.
        a = 8'b11011011;
        s_valid = 1'b1;
        s_data  = a;
        check("t5_ready_idle", s_ready, 1);
        push_exp(0, 2);
        for (int k = 1; k <= DW + M; k++) begin
            tick();
            s_data = 8'($urandom);
            check("t5_ready_shift", s_ready, 0);
            if (k > M) check($sformatf("t5_bit%0d", k - M), det_bit, a[DW - (k - M)]);
        end
        tick();
        check("t5_ready_drain", s_ready, 1);
        s_data = 8'b00000000;
        push_exp(0, 0);
        tick();
        s_valid = 1'b0;
        wait_idle(0);

        check("pre_clr_cnt", match_cnt, exp_cnt);
        cnt_clr = 1'b1;
        tick();
        check("clr_cnt", match_cnt, 0);
        cnt_clr = 1'b0;
        exp_cnt = 0;

        clr_base = clr_cnt;
        for (int i = 0; i < 7; i++)
            send(0, tbl[i].data, (M != 0) ? tbl[i].hits_m : tbl[i].hits_nm, tbl[i].chain);
        check("tbl_final_cnt", match_cnt, exp_cnt);
        check("det_clr_pulses", clr_cnt - clr_base, M * 7);

        // Narrow counter saturates and is cleared by cnt_clr.
        for (int i = 0; i < 4; i++) send(1, 8'b11011011, 2, 1'b0);
        check("t4_sat", match_cnt2, 3);
        cnt_clr2 = 1'b1;
        tick();
        check("t4_clr", match_cnt2, 0);
        cnt_clr2 = 1'b0;
        exp_cnt2 = 0;

        check("sb_empty", sb.size(), 0);
        check("sb2_empty", sb2.size(), 0);

        // Reset in the middle of a word drops it without word_done.
        s_valid = 1'b1;
        s_data  = 8'b11011000;
        check("t6_ready", s_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            s_valid = 1'b0;
        end
        check("t6_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        check_reset("t6");
        exp_cnt  = 0;
        exp_cnt2 = 0;
        snap = done_cnt;
        tick();
        reset = 1'b0;
        repeat (15) tick();
        check("t6_no_done", done_cnt, snap);
        check("t6_cnt", match_cnt, 0);
        check("t6_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
